// File: rtl/delay_len_ctrl.sv
// Tap-length controller for the chip-select delay line: arbitrates button, host
// and sweep requests, and applies a new length only after cs has been idle for a guard time.
module delay_len_ctrl #(
  parameter int LEN_W       = 4,
  parameter int MAX_LEN     = 15,
  parameter int IDLE_CYC    = 4,
  parameter int SWEEP_DWELL = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic             host_wr_valid,
  input  logic [LEN_W-1:0] host_wr_len,
  output logic             host_wr_ready,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic [LEN_W-1:0] len_out,
  output logic             len_update,
  output logic             pending,
  output logic [1:0]       state_dbg
);

  // Handshake: a host write is accepted on any rising clk edge where
  // host_wr_valid && host_wr_ready; ready is low for the whole sweep.

  localparam int GW = $clog2(IDLE_CYC + 1);
  localparam int DW = $clog2(SWEEP_DWELL + 1);
  localparam logic [LEN_W-1:0] MAX_L      = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L      = LEN_W'(1);
  localparam logic [GW-1:0]    GAP_FULL   = GW'(IDLE_CYC);
  localparam logic [DW-1:0]    DWELL_LOAD = DW'(SWEEP_DWELL - 1);

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SW_APPLY   = 2'd1,
    SW_DWELL   = 2'd2,
    SW_RESTORE = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [LEN_W-1:0] target_q, target_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] saved_q, saved_n;
  logic             pending_q, pending_n;
  logic             busy_q, busy_n;
  logic             upd_q, upd_n;
  logic [DW-1:0]    dwell_q, dwell_n;
  logic [GW-1:0]    gap_q;

  logic             gap_ok;
  logic             apply;
  logic [LEN_W-1:0] base;

  assign gap_ok = cs && (gap_q == GAP_FULL);
  assign apply  = pending_q && gap_ok;
  // Requests stack on the not-yet-applied target rather than on len_out.
  assign base   = pending_q ? target_q : len_q;

  always_comb begin
    state_n   = state_q;
    target_n  = target_q;
    len_n     = len_q;
    saved_n   = saved_q;
    pending_n = pending_q;
    busy_n    = busy_q;
    dwell_n   = dwell_q;
    upd_n     = 1'b0;

    if (apply) begin
      len_n     = target_q;
      pending_n = 1'b0;
      upd_n     = (target_q != len_q);
    end

    case (state_q)
      MANUAL: begin
        if (sweep_start && !pending_q) begin
          saved_n   = len_q;
          target_n  = '0;
          pending_n = 1'b1;
          busy_n    = 1'b1;
          state_n   = SW_APPLY;
        end else if (host_wr_valid) begin
          target_n  = (host_wr_len > MAX_L) ? MAX_L : host_wr_len;
          pending_n = 1'b1;
        end else if (dec_pulse) begin
          target_n  = (base == '0) ? MAX_L : base - ONE_L;
          pending_n = 1'b1;
        end else if (inc_pulse) begin
          target_n  = (base == MAX_L) ? '0 : base + ONE_L;
          pending_n = 1'b1;
        end
      end
      SW_APPLY: begin
        if (apply) begin
          dwell_n = DWELL_LOAD;
          state_n = SW_DWELL;
        end
      end
      SW_DWELL: begin
        if (dwell_q == '0) begin
          pending_n = 1'b1;
          if (len_q < MAX_L) begin
            target_n = len_q + ONE_L;
            state_n  = SW_APPLY;
          end else begin
            target_n = saved_q;
            state_n  = SW_RESTORE;
          end
        end else begin
          dwell_n = dwell_q - DW'(1);
        end
      end
      SW_RESTORE: begin
        if (apply) begin
          busy_n  = 1'b0;
          state_n = MANUAL;
        end
      end
      default: state_n = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MANUAL;
      target_q  <= '0;
      len_q     <= '0;
      saved_q   <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
      dwell_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_n;
      target_q  <= target_n;
      len_q     <= len_n;
      saved_q   <= saved_n;
      pending_q <= pending_n;
      busy_q    <= busy_n;
      upd_q     <= upd_n;
      dwell_q   <= dwell_n;
      if (!cs)
        gap_q <= '0;
      else if (gap_q != GAP_FULL)
        gap_q <= gap_q + GW'(1);
    end
  end

  assign host_wr_ready = !busy_q;
  assign sweep_busy    = busy_q;
  assign len_out       = len_q;
  assign len_update    = upd_q;
  assign pending       = pending_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_delay_len_ctrl.sv
// Directed bench for delay_len_ctrl: a vector table for the manual path, plus
// hand sequences for sweep, mid-sweep reset and the clamp on a MAX_LEN=12 instance.
module tb_delay_len_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs, inc_pulse, dec_pulse, host_wr_valid, sweep_start;
  logic [3:0] host_wr_len;
  logic       host_wr_ready, sweep_busy, len_update, pending;
  logic [3:0] len_out;
  logic [1:0] state_dbg;

  logic       cs2, inc2, dec2, hv2;
  logic [3:0] hlen2;
  logic       ready2, busy2, upd2, pend2;
  logic [3:0] len2;
  logic [1:0] state2;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic       cs;
    logic       inc;
    logic       dec;
    logic       hv;
    logic [3:0] hlen;
    logic [3:0] e_len;
    logic       e_pend;
    logic       e_upd;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  delay_len_ctrl #(.LEN_W(4), .MAX_LEN(15), .IDLE_CYC(4), .SWEEP_DWELL(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .host_wr_valid(host_wr_valid), .host_wr_len(host_wr_len), .host_wr_ready(host_wr_ready),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .len_out(len_out),
    .len_update(len_update), .pending(pending), .state_dbg(state_dbg)
  );

  delay_len_ctrl #(.LEN_W(4), .MAX_LEN(12), .IDLE_CYC(4), .SWEEP_DWELL(8)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .cs(cs2), .inc_pulse(inc2), .dec_pulse(dec2),
    .host_wr_valid(hv2), .host_wr_len(hlen2), .host_wr_ready(ready2),
    .sweep_start(1'b0), .sweep_busy(busy2), .len_out(len2),
    .len_update(upd2), .pending(pend2), .state_dbg(state2)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic i, input logic d, input logic h,
                       input logic [3:0] hl);
    cs = c; inc_pulse = i; dec_pulse = d; host_wr_valid = h; host_wr_len = hl;
    sweep_start = 1'b0;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic i, input logic d, input logic h,
                              input logic [3:0] hl, input logic [3:0] el,
                              input logic ep, input logic eu);
    vec_t v;
    v.cs = c; v.inc = i; v.dec = d; v.hv = h; v.hlen = hl;
    v.e_len = el; v.e_pend = ep; v.e_upd = eu;
    return v;
  endfunction

  initial begin
    int pulses;
    int hold;
    int cyc;
    logic done;

    // first inc: applies on the 5th cs-high cycle
    tbl.push_back(mk(1,1,0,0,0, 0,1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,0,1));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0));
    // requests accumulate against the pending target while cs is busy
    tbl.push_back(mk(0,1,0,0,0, 1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 1,1,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 3,0,1));
    tbl.push_back(mk(1,0,0,0,0, 3,0,0));
    // priority host > dec > inc, then wrap at both ends
    tbl.push_back(mk(1,1,1,1,9, 3,1,0));
    tbl.push_back(mk(1,0,0,0,0, 9,0,1));
    tbl.push_back(mk(1,0,0,1,0, 9,1,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,1,0,0, 0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 15,0,1));
    tbl.push_back(mk(1,1,0,0,0, 15,1,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1));
    // request on the apply cycle builds on the target being applied
    tbl.push_back(mk(1,1,0,0,0, 0,1,0));
    tbl.push_back(mk(1,1,0,0,0, 1,1,1));
    tbl.push_back(mk(1,0,0,0,0, 2,0,1));
    // equal-value apply clears pending without a pulse
    tbl.push_back(mk(1,0,0,1,2, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,0,0));
    // cs low every 3rd cycle never lets the gap fill
    tbl.push_back(mk(0,1,0,0,0, 2,1,0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(1,0,0,0,0, 2,1,0));
      tbl.push_back(mk(1,0,0,0,0, 2,1,0));
      tbl.push_back(mk(0,0,0,0,0, 2,1,0));
    end
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,0,0, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0, 3,0,1));

    // reset
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    cs2 = 1'b1; inc2 = 1'b0; dec2 = 1'b0; hv2 = 1'b0; hlen2 = 4'd0;
    tick(); tick(); tick();
    chk("reset len_out", len_out, 0);
    chk("reset pending", pending, 0);
    chk("reset len_update", len_update, 0);
    chk("reset sweep_busy", sweep_busy, 0);
    chk("reset host_wr_ready", host_wr_ready, 1);
    chk("reset state", state_dbg, 0);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].cs, tbl[r].inc, tbl[r].dec, tbl[r].hv, tbl[r].hlen);
      tick();
      chk($sformatf("row%0d len_out", r), len_out, tbl[r].e_len);
      chk($sformatf("row%0d pending", r), pending, tbl[r].e_pend);
      chk($sformatf("row%0d len_update", r), len_update, tbl[r].e_upd);
      chk($sformatf("row%0d ready", r), host_wr_ready, 1);
      chk($sformatf("row%0d busy", r), sweep_busy, 0);
    end

    // set length 5, then sweep with inc and host writes held on throughout
    drive(1, 0, 0, 1, 5);
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    chk("pre-sweep len_out", len_out, 5);
    for (int v = 0; v <= 15; v++) exp_q.push_back(4'(v));
    exp_q.push_back(4'd5);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("sweep start busy", sweep_busy, 1);
    chk("sweep start state", state_dbg, 1);
    pulses = 0; hold = 0; done = 1'b0;
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      inc_pulse = 1'b1; host_wr_valid = 1'b1; host_wr_len = 4'd9;
      chk("sweep host_wr_ready", host_wr_ready, 0);
      tick();
      if (len_update) begin
        if (exp_q.size() == 0) begin
          chk("sweep extra pulse", 1, 0);
          done = 1'b1;
        end else begin
          chk($sformatf("sweep step%0d len_out", pulses), len_out, exp_q.pop_front());
          if (pulses > 0) chk($sformatf("sweep step%0d hold>=8", pulses), int'(hold >= 8), 1);
          chk($sformatf("sweep step%0d busy", pulses), sweep_busy, (exp_q.size() == 0) ? 0 : 1);
          if (exp_q.size() == 0) done = 1'b1;
        end
        pulses++;
        hold = 0;
      end else begin
        hold++;
      end
    end
    drive(1, 0, 0, 0, 0);
    chk("sweep finished in budget", done, 1);
    chk("sweep pulse count", pulses, 17);
    tick();
    chk("post-sweep len_out", len_out, 5);
    chk("post-sweep busy", sweep_busy, 0);
    chk("post-sweep ready", host_wr_ready, 1);
    chk("post-sweep pending", pending, 0);

    // reset in the middle of a sweep
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    done = 1'b0;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      if (len_out == 4'd6) done = 1'b1;
    end
    chk("sweep reached step 6", done, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-sweep reset len_out", len_out, 0);
    chk("mid-sweep reset busy", sweep_busy, 0);
    chk("mid-sweep reset pending", pending, 0);
    chk("mid-sweep reset ready", host_wr_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    drive(1, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    chk("post-reset inc pending", pending, 1);
    tick(); tick(); tick();
    chk("post-reset len before gap", len_out, 0);
    tick();
    chk("post-reset inc len_out", len_out, 1);
    chk("post-reset inc len_update", len_update, 1);

    // MAX_LEN=12 instance: clamp and wrap
    tick(); tick();
    hv2 = 1'b1; hlen2 = 4'd14;
    tick();
    hv2 = 1'b0;
    tick();
    chk("clamp len_out", len2, 12);
    chk("clamp len_update", upd2, 1);
    inc2 = 1'b1;
    tick();
    inc2 = 1'b0;
    tick();
    chk("wrap12 inc len_out", len2, 0);
    dec2 = 1'b1;
    tick();
    dec2 = 1'b0;
    tick();
    chk("wrap12 dec len_out", len2, 12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
